// File: rtl/player_motion_ctrl.sv
// Player sprite walk/jump/gravity engine, stepped once per video frame.
// Optional air jump enabled by defining PLAYER_DOUBLE_JUMP_EN.
module player_motion_ctrl #(
  parameter int X_START      = 40,
  parameter int Y_START      = 280,
  parameter int X_MIN        = 0,
  parameter int X_MAX        = 480,
  parameter int Y_MIN        = 0,
  parameter int Y_MAX        = 360,
  parameter int SPRITE_W     = 20,
  parameter int WALK_STEP    = 1,
  parameter int RISE_STEP    = 4,
  parameter int RISE_FRAMES  = 20,
  parameter int APEX_FRAMES  = 15,
  parameter int GRAVITY_STEP = 1,
  parameter int MAX_FALL     = 6,
  parameter logic [7:0] KEY_LEFT  = 8'h04,
  parameter logic [7:0] KEY_RIGHT = 8'h07,
  parameter logic [7:0] KEY_JUMP  = 8'h1A
) (
  input  logic        clk_125MHz,
  input  logic        Reset_n,
  input  logic        frame_tick,
  input  logic [15:0] keycode,
  input  logic        on_ground,
  input  logic        wall_left,
  input  logic        wall_right,
  input  logic        wall_above,
  input  logic [9:0]  ground_y,
  input  logic        Win,
  input  logic        Dead,
  output logic [9:0]  ManX,
  output logic [9:0]  ManY,
  output logic        towards_left,
  output logic        jumping,
  output logic [2:0]  motion_state
);

  typedef enum logic [2:0] {
    S_GROUND = 3'd0,
    S_RISE   = 3'd1,
    S_HOVER  = 3'd2,
    S_FALL   = 3'd3,
    S_FROZEN = 3'd4
  } state_t;

  localparam logic [9:0]  XS   = 10'(X_START);
  localparam logic [9:0]  YS   = 10'(Y_START);
  localparam logic [10:0] XLO  = 11'(X_MIN);
  localparam logic [10:0] XHI  = 11'(X_MAX - SPRITE_W);
  localparam logic [10:0] YLO  = 11'(Y_MIN);
  localparam logic [10:0] YHI  = 11'(Y_MAX);
  localparam logic [10:0] WSTP = 11'(WALK_STEP);
  localparam logic [10:0] RSTP = 11'(RISE_STEP);
  localparam logic [10:0] GSTP = 11'(GRAVITY_STEP);
  localparam logic [10:0] VMAX = 11'(MAX_FALL);
  localparam logic [7:0]  RLST = 8'(RISE_FRAMES - 1);
  localparam logic [7:0]  ALST = 8'(APEX_FRAMES - 1);

  state_t      state_q, state_d;
  logic [9:0]  x_q, x_d, y_q, y_d;
  logic        left_q, left_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [3:0]  vel_q, vel_d;
`ifdef PLAYER_DOUBLE_JUMP_EN
  logic        kj_q, kj_d;
  logic        air_q, air_d;
  logic        dj;
`endif

  logic k_l, k_r, k_j;
  assign k_l = (keycode[7:0] == KEY_LEFT)  || (keycode[15:8] == KEY_LEFT);
  assign k_r = (keycode[7:0] == KEY_RIGHT) || (keycode[15:8] == KEY_RIGHT);
  assign k_j = (keycode[7:0] == KEY_JUMP)  || (keycode[15:8] == KEY_JUMP);

`ifdef PLAYER_DOUBLE_JUMP_EN
  // air jump: fresh press of jump while an air jump is still banked
  assign dj = k_j && !kj_q && air_q;
`endif

  // next-state: horizontal walk, vertical FSM, freeze on game over
  always_comb begin
    logic [10:0] xn, yn, vn;
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    left_d  = left_q;
    cnt_d   = cnt_q;
    vel_d   = vel_q;
    xn      = '0;
    yn      = '0;
    vn      = '0;
`ifdef PLAYER_DOUBLE_JUMP_EN
    kj_d    = kj_q;
    air_d   = air_q;
`endif
    if (frame_tick) begin
`ifdef PLAYER_DOUBLE_JUMP_EN
      kj_d = k_j;
`endif
      if (state_q == S_FROZEN) begin
        state_d = S_FROZEN;
      end else if (Win || Dead) begin
        state_d = S_FROZEN;
      end else begin
        if (k_l && k_r) begin
          left_d = left_q;
        end else if (k_r) begin
          left_d = 1'b0;
          if (!wall_right) begin
            xn = {1'b0, x_q} + WSTP;
            if (xn > XHI) xn = XHI;
            x_d = xn[9:0];
          end
        end else if (k_l) begin
          left_d = 1'b1;
          if (!wall_left) begin
            xn = {1'b0, x_q};
            if (xn < XLO + WSTP) xn = XLO;
            else                 xn = xn - WSTP;
            x_d = xn[9:0];
          end
        end

        case (state_q)
          S_GROUND: begin
            if (k_j && on_ground) begin
              state_d = S_RISE;
              cnt_d   = '0;
            end else if (!on_ground) begin
              state_d = S_FALL;
              vel_d   = '0;
            end
          end
          S_RISE: begin
            if (wall_above) begin
              state_d = S_FALL;
              vel_d   = '0;
`ifdef PLAYER_DOUBLE_JUMP_EN
            end else if (dj) begin
              cnt_d = '0;
              air_d = 1'b0;
`endif
            end else begin
              yn = {1'b0, y_q};
              if (yn < YLO + RSTP) yn = YLO;
              else                 yn = yn - RSTP;
              y_d   = yn[9:0];
              cnt_d = cnt_q + 8'd1;
              if (cnt_q == RLST) begin
                state_d = S_HOVER;
                cnt_d   = '0;
              end
            end
          end
          S_HOVER: begin
`ifdef PLAYER_DOUBLE_JUMP_EN
            if (dj) begin
              state_d = S_RISE;
              cnt_d   = '0;
              air_d   = 1'b0;
            end else
`endif
            if (cnt_q == ALST) begin
              state_d = S_FALL;
              vel_d   = '0;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + 8'd1;
            end
          end
          S_FALL: begin
`ifdef PLAYER_DOUBLE_JUMP_EN
            if (dj) begin
              state_d = S_RISE;
              cnt_d   = '0;
              air_d   = 1'b0;
            end else
`endif
            begin
              vn = {7'b0, vel_q} + GSTP;
              if (vn > VMAX) vn = VMAX;
              yn = {1'b0, y_q} + vn;
              if (yn >= {1'b0, ground_y}) begin
                y_d     = ground_y;
                state_d = S_GROUND;
                vel_d   = '0;
`ifdef PLAYER_DOUBLE_JUMP_EN
                air_d   = 1'b1;
`endif
              end else begin
                if (yn > YHI) yn = YHI;
                y_d   = yn[9:0];
                vel_d = vn[3:0];
              end
            end
          end
          default: state_d = state_q;
        endcase
      end
    end
  end

  // state registers, async active-low reset
  always_ff @(posedge clk_125MHz or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= S_GROUND;
      x_q     <= XS;
      y_q     <= YS;
      left_q  <= 1'b0;
      cnt_q   <= '0;
      vel_q   <= '0;
`ifdef PLAYER_DOUBLE_JUMP_EN
      kj_q    <= 1'b0;
      air_q   <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      left_q  <= left_d;
      cnt_q   <= cnt_d;
      vel_q   <= vel_d;
`ifdef PLAYER_DOUBLE_JUMP_EN
      kj_q    <= kj_d;
      air_q   <= air_d;
`endif
    end
  end

  assign ManX         = x_q;
  assign ManY         = y_q;
  assign towards_left = left_q;
  assign jumping      = (state_q == S_RISE) || (state_q == S_HOVER);
  assign motion_state = state_q;

endmodule
